// File: rtl/sevenseg_pkg.sv
// Shared types, constants and the hex-to-segment decode table for the
// seven-segment scan driver. All segment values here are active-low,
// ordered {dp,g,f,e,d,c,b,a}.
package sevenseg_pkg;

    typedef logic [7:0] seg_t;

    // All segments dark, active-low.
    localparam seg_t SEG_OFF = 8'hFF;
    // Bit position of the decimal point inside a seg_t.
    localparam int DP_BIT = 7;

    // Hex nibble to active-low segment pattern; decimal point left dark.
    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational hex nibble decoder producing an active-low segment pattern
// with the decimal point dark.
module hex_to_sevenseg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver. One digit is
// enabled per dwell period; digit data is shadowed once per frame so a frame
// never shows a mix of old and new values. Brightness is a live PWM gate
// derived from the top nibble of the dwell counter.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV_BITS = 11,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic [NUM_DIGITS-1:0]   blank_en,
    input  logic                    lead_zero_blank,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   display_sel,
    output logic [7:0]              display,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Idle values of the pins, in board polarity.
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE  = ACTIVE_LOW ? '1 : '0;
    localparam seg_t                  DISP_IDLE = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;

    // ------------------------------------------------------------------
    // Scan position
    // ------------------------------------------------------------------
    logic [SCAN_DIV_BITS-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     dwell_wrap;
    logic                     frame_wrap;

    assign dwell_wrap = &cnt_q;
    assign frame_wrap = dwell_wrap && (idx_q == LAST_IDX);

    // Next scan position: counter always advances, index steps on dwell wrap
    // and returns to 0 explicitly after the last digit.
    always_comb begin
        cnt_d = cnt_q + SCAN_DIV_BITS'(1);
        idx_d = idx_q;
        if (dwell_wrap) begin
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Scan position registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame shadow registers
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    lzb_q, lzb_d;

    // Capture the display content only on the wrap to digit 0.
    always_comb begin
        digits_d = digits_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        lzb_d    = lzb_q;
        if (frame_wrap) begin
            digits_d = digits;
            dp_d     = dp_en;
            blank_d  = blank_en;
            lzb_d    = lead_zero_blank;
        end
    end

    // Shadow register storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            digits_q <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            lzb_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            lzb_q    <= lzb_d;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression mask
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] supp_mask;
    logic                  zero_run;

    // Walk from the most significant digit down; a digit is suppressed while
    // it and everything above it is zero. Digit 0 always stays visible.
    always_comb begin
        supp_mask = '0;
        zero_run  = lzb_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && (digits_q[4*i +: 4] == 4'h0);
            supp_mask[i] = zero_run;
        end
    end

    // ------------------------------------------------------------------
    // Current digit selection
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] onehot;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
            assign onehot[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic       cur_blank;
    logic       cur_supp;

    // Mux the shadowed fields of the digit currently being scanned.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_supp   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (onehot[i]) begin
                cur_nibble = digits_q[4*i +: 4];
                cur_dp     = dp_q[i];
                cur_blank  = blank_q[i];
                cur_supp   = supp_mask[i];
            end
        end
    end

    seg_t dec_seg;

    hex_to_sevenseg u_decode (
        .nibble_i (cur_nibble),
        .seg_o    (dec_seg)
    );

    // ------------------------------------------------------------------
    // Brightness, lit decision and output formatting
    // ------------------------------------------------------------------
    logic pwm_on;
    logic lit;

    assign pwm_on = (brightness == 4'hF) ||
                    (cnt_q[SCAN_DIV_BITS-1 -: 4] < brightness);
    assign lit    = !cur_blank && !cur_supp && pwm_on;

    seg_t                  seg_al;
    logic [NUM_DIGITS-1:0] sel_ah;
    logic [NUM_DIGITS-1:0] sel_d;
    seg_t                  disp_d;

    // Build the next pin values: decoded pattern with optional dp, forced
    // dark when unlit; digit enables held off for the first two clocks of a
    // dwell so segment changes never ghost onto the next digit.
    always_comb begin
        seg_al = SEG_OFF;
        if (lit) begin
            seg_al = dec_seg;
            if (cur_dp) begin
                seg_al[DP_BIT] = 1'b0;
            end
        end
        sel_ah = onehot;
        if (cnt_q[SCAN_DIV_BITS-1:1] == '0) begin
            sel_ah = '0;
        end
        disp_d = ACTIVE_LOW ? seg_al : ~seg_al;
        sel_d  = ACTIVE_LOW ? ~sel_ah : sel_ah;
    end

    logic [NUM_DIGITS-1:0] sel_q;
    seg_t                  disp_q;

    // Registered pins, idle (everything dark) in reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q  <= SEL_IDLE;
            disp_q <= DISP_IDLE;
        end else begin
            sel_q  <= sel_d;
            disp_q <= disp_d;
        end
    end

    assign display_sel = sel_q;
    assign display     = disp_q;
    assign frame_done  = frame_wrap;

endmodule
